// File: rtl/keccak_seq_if.sv
// Handshake and strobe bundle between the Keccak sequencer and its host/datapath.
interface keccak_seq_if #(
  parameter int unsigned RATE_W = 17,
  parameter int unsigned NR     = 24,
  parameter int unsigned SQ_W   = 8
);
  localparam int unsigned WI_W = (RATE_W > 1) ? $clog2(RATE_W) : 1;
  localparam int unsigned RI_W = (NR > 1) ? $clog2(NR) : 1;

  logic            start;
  logic            abort;
  logic            xof;
  logic [SQ_W-1:0] sq_blocks;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic            state_clr;
  logic            absorb_we;
  logic            pad_en;
  logic [WI_W-1:0] word_idx;
  logic            round_en;
  logic [RI_W-1:0] round_idx;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  modport master (
    output start, abort, xof, sq_blocks, in_valid, in_last, out_ready,
    input  in_ready, state_clr, absorb_we, pad_en, word_idx,
           round_en, round_idx, out_valid, busy, done
  );

  modport slave (
    input  start, abort, xof, sq_blocks, in_valid, in_last, out_ready,
    output in_ready, state_clr, absorb_we, pad_en, word_idx,
           round_en, round_idx, out_valid, busy, done
  );
endinterface

// File: rtl/keccak_seq_ctrl.sv
// Keccak sponge sequencer: absorb words, pad, run rounds, squeeze (fixed or XOF).
module keccak_seq_ctrl #(
  parameter int unsigned RATE_W = 17,
  parameter int unsigned NR     = 24,
  parameter int unsigned SQ_W   = 8
) (
  input logic          clk,
  input logic          rst_n,
  keccak_seq_if.slave  bus
);
  localparam int unsigned WI_W = (RATE_W > 1) ? $clog2(RATE_W) : 1;
  localparam int unsigned RI_W = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [WI_W-1:0] LAST_WORD  = WI_W'(RATE_W - 1);
  localparam logic [RI_W-1:0] LAST_ROUND = RI_W'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_PERMUTE, S_SQUEEZE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WI_W-1:0] word_cnt_q, word_cnt_d;
  logic [RI_W-1:0] round_cnt_q, round_cnt_d;
  logic [SQ_W-1:0] sq_cnt_q, sq_cnt_d;
  logic [SQ_W-1:0] sq_blocks_q, sq_blocks_d;
  logic            xof_q, xof_d;
  logic            pend_pad_q, pend_pad_d;
  logic            msg_end_q, msg_end_d;
  logic            clr_q, clr_d;
  logic            accept_c;

  // A word is taken only when ready and not being aborted in the same cycle
  assign accept_c     = bus.in_valid & bus.in_ready & ~bus.abort;
  assign bus.absorb_we = accept_c;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      round_cnt_q <= '0;
      sq_cnt_q    <= '0;
      sq_blocks_q <= '0;
      xof_q       <= 1'b0;
      pend_pad_q  <= 1'b0;
      msg_end_q   <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      round_cnt_q <= round_cnt_d;
      sq_cnt_q    <= sq_cnt_d;
      sq_blocks_q <= sq_blocks_d;
      xof_q       <= xof_d;
      pend_pad_q  <= pend_pad_d;
      msg_end_q   <= msg_end_d;
      clr_q       <= clr_d;
    end
  end

  // Next-state and counter update; abort overrides every transition
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    round_cnt_d = round_cnt_q;
    sq_cnt_d    = sq_cnt_q;
    sq_blocks_d = sq_blocks_q;
    xof_d       = xof_q;
    pend_pad_d  = pend_pad_q;
    msg_end_d   = msg_end_q;
    clr_d       = 1'b0;

    if (bus.abort) begin
      state_d     = S_IDLE;
      word_cnt_d  = '0;
      round_cnt_d = '0;
      sq_cnt_d    = '0;
      pend_pad_d  = 1'b0;
      msg_end_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d     = S_ABSORB;
            clr_d       = 1'b1;
            word_cnt_d  = '0;
            round_cnt_d = '0;
            sq_cnt_d    = '0;
            pend_pad_d  = 1'b0;
            msg_end_d   = 1'b0;
            xof_d       = bus.xof;
            sq_blocks_d = bus.sq_blocks;
          end
        end
        S_ABSORB: begin
          if (accept_c) begin
            if (word_cnt_q == LAST_WORD) begin
              // Full block: permute first; a final full block pads in a fresh block
              state_d    = S_PERMUTE;
              word_cnt_d = '0;
              pend_pad_d = bus.in_last;
            end else if (bus.in_last) begin
              state_d    = S_PAD;
              word_cnt_d = word_cnt_q + WI_W'(1);
            end else begin
              word_cnt_d = word_cnt_q + WI_W'(1);
            end
          end
        end
        S_PAD: begin
          state_d   = S_PERMUTE;
          msg_end_d = 1'b1;
        end
        S_PERMUTE: begin
          if (round_cnt_q == LAST_ROUND) begin
            round_cnt_d = '0;
            word_cnt_d  = '0;
            if (pend_pad_q) begin
              state_d    = S_PAD;
              pend_pad_d = 1'b0;
            end else if (msg_end_q) begin
              state_d = S_SQUEEZE;
            end else begin
              state_d = S_ABSORB;
            end
          end else begin
            round_cnt_d = round_cnt_q + RI_W'(1);
          end
        end
        S_SQUEEZE: begin
          if (bus.out_ready) begin
            if (!xof_q || (sq_cnt_q == sq_blocks_q)) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_PERMUTE;
              sq_cnt_d = sq_cnt_q + SQ_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state; abort masks datapath strobes in its own cycle
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.state_clr = clr_q;
    bus.pad_en    = 1'b0;
    bus.word_idx  = '0;
    bus.round_en  = 1'b0;
    bus.round_idx = '0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    unique case (state_q)
      S_IDLE: bus.busy = 1'b0;
      S_ABSORB: begin
        // Hold off words while the datapath is being cleared
        bus.in_ready = ~clr_q;
        bus.word_idx = word_cnt_q;
      end
      S_PAD: begin
        bus.pad_en   = ~bus.abort;
        bus.word_idx = word_cnt_q;
      end
      S_PERMUTE: begin
        bus.round_en  = ~bus.abort;
        bus.round_idx = round_cnt_q;
      end
      S_SQUEEZE: bus.out_valid = 1'b1;
      S_DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_keccak_seq_ctrl.sv
// Randomized bench for keccak_seq_ctrl against a sponge-level event model.
`timescale 1ns/1ps
module tb_keccak_seq_ctrl;
  localparam int unsigned RATE_W = 17;
  localparam int unsigned NR     = 24;
  localparam int unsigned SQ_W   = 8;
  localparam int          BUDGET = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  keccak_seq_if #(.RATE_W(RATE_W), .NR(NR), .SQ_W(SQ_W)) bus ();

  keccak_seq_ctrl #(.RATE_W(RATE_W), .NR(NR), .SQ_W(SQ_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // All DUT outputs packed for all-zero checks
  function automatic logic [17:0] outs();
    return {bus.in_ready, bus.state_clr, bus.absorb_we, bus.pad_en, bus.word_idx,
            bus.round_en, bus.round_idx, bus.out_valid, bus.busy, bus.done};
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.xof = 1'b0; bus.sq_blocks = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
  endtask

  // One full message: expected strobe events come from sponge arithmetic
  // (1000+lane = absorb, 2000+lane = pad, 3000+r = round, 4000 = output block)
  task automatic run_msg(input string name, input int len, input bit x, input int sq,
                         input int stall2, input bit noise);
    int exp_q[$];
    int got_q[$];
    int sent = 0, blk = 0, wait_cnt = 0, clr_cnt = 0, cyc = 0, stall_seen = -1, prev_ri = 0;
    int nblk, bad_i;
    bit timing_ok = 1'b1, finished = 1'b0, first = 1'b1;
    bit prev_re = 1'b0, prev_pad = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;

    for (int i = 0; i < len; i++) begin
      exp_q.push_back(1000 + i % RATE_W);
      if (i % RATE_W == RATE_W - 1)
        for (int r = 0; r < NR; r++) exp_q.push_back(3000 + r);
    end
    exp_q.push_back(2000 + len % RATE_W);
    for (int r = 0; r < NR; r++) exp_q.push_back(3000 + r);
    nblk = x ? sq + 1 : 1;
    for (int b = 0; b < nblk; b++) begin
      if (b > 0) for (int r = 0; r < NR; r++) exp_q.push_back(3000 + r);
      exp_q.push_back(4000);
    end

    @(negedge clk);
    bus.start = 1'b1; bus.xof = x; bus.sq_blocks = SQ_W'(sq); bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      bus.start = noise && bus.busy && ($urandom % 6 == 0);
      if (noise) begin
        bus.xof = 1'($urandom % 2);
        bus.sq_blocks = SQ_W'($urandom);
      end
      if (sent < len && bus.in_ready) begin
        bus.in_valid = ($urandom % 4 != 0);
        bus.in_last  = (sent == len - 1);
      end else if (noise && !bus.in_ready) begin
        bus.in_valid = 1'($urandom % 2);
        bus.in_last  = 1'($urandom % 2);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
      if (bus.out_valid)
        bus.out_ready = (blk == 1 && stall2 >= 0) ? (wait_cnt >= stall2) : ($urandom % 3 == 0);
      else
        bus.out_ready = noise ? 1'($urandom % 2) : 1'b0;
      #1;
      if (first) begin
        first = 1'b0;
        n_tests++;
        if (bus.state_clr !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s start_ack: clr=%b done=%b busy=%b, want 1 0 1",
                   name, bus.state_clr, bus.done, bus.busy);
        end
      end
      if (bus.state_clr) clr_cnt++;
      if (bus.absorb_we) begin
        got_q.push_back(1000 + int'(bus.word_idx));
        sent++;
      end
      if (bus.pad_en) got_q.push_back(2000 + int'(bus.word_idx));
      if (prev_pad && !(bus.round_en && bus.round_idx == 0)) timing_ok = 1'b0;
      if (bus.round_en) begin
        got_q.push_back(3000 + int'(bus.round_idx));
        if (bus.round_idx == 0) begin
          if (prev_re) timing_ok = 1'b0;
        end else if (!prev_re || prev_ri != int'(bus.round_idx) - 1) begin
          timing_ok = 1'b0;
        end
      end else if (prev_re && prev_ri != NR - 1) begin
        timing_ok = 1'b0;
      end
      if (prev_ov && !prev_or && !bus.out_valid) timing_ok = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(4000);
        if (blk == 1) stall_seen = wait_cnt;
        blk++;
        wait_cnt = 0;
      end else if (bus.out_valid) begin
        wait_cnt++;
      end
      prev_re = bus.round_en; prev_ri = int'(bus.round_idx); prev_pad = bus.pad_en;
      prev_ov = bus.out_valid; prev_or = bus.out_ready;
      if (bus.done) finished = 1'b1;
    end
    idle_inputs();

    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL %s done_timeout: done not seen after %0d cycles", name, cyc);
    end
    n_tests++;
    bad_i = -1;
    for (int i = 0; i < exp_q.size() || i < got_q.size(); i++) begin
      if (bad_i < 0 && (i >= exp_q.size() || i >= got_q.size() || exp_q[i] != got_q[i])) bad_i = i;
    end
    if (bad_i >= 0) begin
      n_fail++;
      $display("FAIL %s event_seq: at event %0d got %0d want %0d (got %0d events, want %0d)", name,
               bad_i, (bad_i < got_q.size()) ? got_q[bad_i] : -1,
               (bad_i < exp_q.size()) ? exp_q[bad_i] : -1, got_q.size(), exp_q.size());
    end
    n_tests++;
    if (!timing_ok) begin
      n_fail++;
      $display("FAIL %s timing: round/pad/out_valid timing broken, got 0 want 1", name);
    end
    n_tests++;
    if (clr_cnt != 1) begin
      n_fail++;
      $display("FAIL %s clr_pulses: got %0d want 1", name, clr_cnt);
    end
    if (stall2 >= 0) begin
      n_tests++;
      if (stall_seen != stall2) begin
        n_fail++;
        $display("FAIL %s stall_len: got %0d want %0d", name, stall_seen, stall2);
      end
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_state: busy=%b ov=%b rdy=%b want 0 0 0",
               name, bus.busy, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h want 0", outs());
    end
  endtask

  task automatic test_fixed_3word();
    run_msg("fixed3", 3, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_full_block();
    run_msg("full17", 17, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_xof_stall();
    run_msg("xof_sq2", 4, 1'b1, 2, 5, 1'b0);
  endtask

  task automatic test_abort();
    int sent = 0;
    bit hit = 1'b0;
    // abort while a word is offered in ABSORB
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.abort = 1'b1;
    #1;
    n_tests++;
    if (bus.absorb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_absorb_we: got %b want 0", bus.absorb_we);
    end
    @(negedge clk); bus.abort = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL abort_absorb_idle: got %h want 0", outs());
    end
    // abort at round 10 of the pad permutation
    @(negedge clk); bus.start = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.round_en && bus.round_idx == 10) begin
        hit = 1'b1;
        bus.in_valid = 1'b0;
        bus.abort = 1'b1;
        #1;
        n_tests++;
        if (bus.round_en !== 1'b0 || bus.pad_en !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_round_en: round_en=%b pad_en=%b want 0 0", bus.round_en, bus.pad_en);
        end
      end else begin
        bus.in_valid = bus.in_ready && sent < 2;
        bus.in_last  = (sent == 1);
        #1;
        if (bus.absorb_we) sent++;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_reach_round10: got 0 want 1");
    end
    @(negedge clk); idle_inputs();
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL abort_idle_next: got %h want 0", outs());
    end
    run_msg("after_abort", 6, 1'b0, 0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_last = 1'b0;
      #1;
      if (bus.absorb_we && bus.word_idx == 7) hit = 1'b1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_reach_word7: got 0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL rst_async_zero: got %h want 0", outs());
    end
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL rst_start_ignored: got %h want 0", outs());
    end
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    n_tests++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL rst_discard: got %h want 0", outs());
    end
    run_msg("after_reset", 9, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_restart_done();
    #1;
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pre_done: got %b want 1", bus.done);
    end
    run_msg("restart_a", 5, 1'b0, 0, -1, 1'b0);
    run_msg("restart_b", 20, 1'b1, 1, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_msg("rand", 1 + int'($urandom % 40), 1'($urandom % 2), int'($urandom % 4), -1, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed_3word();
    test_full_block();
    test_xof_stall();
    test_restart_done();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keccak_seq_ctrl.md
KECCAK_SEQ_CTRL -- requirements
Module: keccak_seq_ctrl

Interface
REQ-001 SHALL have parameter RATE_W, default 17, meaning words per rate block (range 2..21).
REQ-002 SHALL have parameter NR, default 24, meaning permutation rounds (range 1..24).
REQ-003 SHALL have parameter SQ_W, default 8, meaning width of XOF block-count input.
REQ-004 SHALL have clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  in  1  begin new message; accepted only in IDLE or DONE.
REQ-007 SHALL have abort  in  1  synchronous abort to IDLE.
REQ-008 SHALL have xof  in  1  mode, sampled with start: 0 = fixed hash, 1 = XOF.
REQ-009 SHALL have sq_blocks  in  SQ_W  XOF output block count minus 1, sampled with start.
REQ-010 SHALL have in_valid / in_last  in  1 / 1  input word valid; final message word.
REQ-011 SHALL have in_ready  out  1  high only in ABSORB.
REQ-012 SHALL have state_clr  out  1  one-cycle pulse clearing datapath state.
REQ-013 SHALL have absorb_we  out  1  XOR input word into lane word_idx (= in_valid & in_ready).
REQ-014 SHALL have pad_en  out  1  apply pad10*1 plus domain suffix at word_idx.
REQ-015 SHALL have word_idx  out  $clog2(RATE_W)  current lane index.
REQ-016 SHALL have round_en / round_idx  out  1 / $clog2(NR)  execute round round_idx this cycle.
REQ-017 SHALL have out_valid / out_ready  out / in  1 / 1  squeeze block handshake.
REQ-018 SHALL have busy / done  out  1 / 1  not IDLE/DONE; level high in DONE.

Function
REQ-019 SHALL implement states IDLE, ABSORB, PAD, PERMUTE, SQUEEZE, DONE.
REQ-020 SHALL, from IDLE or DONE on start, pulse state_clr for one cycle, clear word_cnt, sq_cnt, and pend_pad, latch xof/sq_blocks, and enter ABSORB next cycle.
REQ-021 SHALL, in ABSORB on accepted word, increment word_cnt; if word_cnt == RATE_W-1, go to PERMUTE.
REQ-022 SHALL, in ABSORB on in_last with word_cnt < RATE_W-1, go to PAD with word_idx = word_cnt+1.
REQ-023 SHALL, in ABSORB on in_last at word_cnt == RATE_W-1 (full block), go to PERMUTE and set pend_pad; after that permutation enter PAD with word_idx = 0.
REQ-024 SHALL hold PAD for exactly one cycle with pad_en = 1, then enter PERMUTE and set msg_end.
REQ-025 SHALL, in PERMUTE, assert round_en for exactly NR consecutive cycles, round_idx 0..NR-1, then leave.
REQ-026 SHALL, on PERMUTE exit, go to PAD if pend_pad (clearing it), else SQUEEZE if msg_end, else ABSORB with word_cnt = 0.
REQ-027 SHALL, in SQUEEZE, hold out_valid = 1 until out_ready; with xof = 0 or sq_cnt == sq_blocks, the handshake goes to DONE, else PERMUTE with sq_cnt+1.
REQ-028 SHALL keep out_valid stable and never deassert it without a handshake.
REQ-029 SHALL ignore start outside IDLE/DONE; in_valid outside ABSORB SHALL produce no absorb_we.
REQ-030 SHALL give abort priority over every transition: the next state is IDLE, counters clear, and no absorb_we/pad_en/round_en occurs that cycle.
REQ-031 SHALL assert start in DONE as a restart and SHALL deassert done on the following cycle.
REQ-032 SHALL drive all outputs as functions of the registered state and counters only, except absorb_we (in_valid & in_ready).

Reset
REQ-033 SHALL, on rst_n low at any time, asynchronously enter IDLE and clear all counters, pend_pad, msg_end, and latched mode.
REQ-034 SHALL drive all outputs to 0 during reset, including word_idx and round_idx.
REQ-035 SHALL require a new start after reset release; an in-progress message SHALL be discarded.

Verification
REQ-036 SHALL verify 3-word message, xof = 0: words at idx 0..2, pad_en at idx 3, 24 round_en cycles, one out_valid, then done = 1.
REQ-037 SHALL verify 17-word message (in_last on idx 16): PERMUTE 24 cycles, then PAD at idx 0, then PERMUTE 24 cycles, then SQUEEZE.
REQ-038 SHALL verify xof = 1, sq_blocks = 2: three out_valid handshakes separated by 24-cycle permutations, with out_ready stalled 5 cycles on the second.
REQ-039 SHALL verify abort mid-PERMUTE at round 10: IDLE next cycle, round_en = 0, then restart completes normally.
REQ-040 SHALL verify rst_n pulled low during ABSORB at word 7: outputs immediately 0, start ignored while rst_n low.
REQ-041 SHALL verify start in DONE: state_clr pulse, done falls, and a second message hashes correctly.
